// File: rtl/l2_intl_xbar.sv
// Word-interleaved TCDM-to-L2 crossbar: one round-robin arbiter per bank,
// combinational request forwarding and a one-cycle response return path.
module l2_intl_xbar #(
    parameter int NB_MASTERS = 4,
    parameter int NB_BANKS   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NB_MASTERS-1:0]    m_req_i,
    input  logic [32*NB_MASTERS-1:0] m_add_i,
    input  logic [NB_MASTERS-1:0]    m_wen_i,
    input  logic [32*NB_MASTERS-1:0] m_wdata_i,
    input  logic [4*NB_MASTERS-1:0]  m_be_i,
    output logic [NB_MASTERS-1:0]    m_gnt_o,
    output logic [NB_MASTERS-1:0]    m_r_valid_o,
    output logic [32*NB_MASTERS-1:0] m_r_rdata_o,
    output logic [NB_BANKS-1:0]      b_req_o,
    output logic [32*NB_BANKS-1:0]   b_add_o,
    output logic [NB_BANKS-1:0]      b_wen_o,
    output logic [32*NB_BANKS-1:0]   b_wdata_o,
    output logic [4*NB_BANKS-1:0]    b_be_o,
    input  logic [NB_BANKS-1:0]      b_gnt_i,
    input  logic [NB_BANKS-1:0]      b_r_valid_i,
    input  logic [32*NB_BANKS-1:0]   b_r_rdata_i
);

    localparam int BSEL_W = $clog2(NB_BANKS);
    localparam int PTR_W  = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

    logic [BSEL_W-1:0] tgt     [NB_MASTERS];
    logic [PTR_W-1:0]  ptr     [NB_BANKS];
    logic [PTR_W-1:0]  ptr_nxt [NB_BANKS];
    logic [PTR_W-1:0]  win     [NB_BANKS];
    logic [PTR_W-1:0]  owner   [NB_BANKS];
    logic [NB_BANKS-1:0] any_req;
    logic [NB_BANKS-1:0] bank_gnt;
    logic [NB_BANKS-1:0] pending;

    always_comb begin
        for (int m = 0; m < NB_MASTERS; m++) begin
            tgt[m] = m_add_i[32*m+2 +: BSEL_W];
        end
    end

    // Arbitration: first requester at or after the bank pointer, wrapping.
    always_comb begin
        int idx;
        idx = 0;
        for (int b = 0; b < NB_BANKS; b++) begin
            any_req[b] = 1'b0;
            win[b]     = '0;
            for (int i = 0; i < NB_MASTERS; i++) begin
                idx = (int'(ptr[b]) + i) % NB_MASTERS;
                if (!any_req[b] && m_req_i[idx] && (tgt[idx] == BSEL_W'(b))) begin
                    any_req[b] = 1'b1;
                    win[b]     = PTR_W'(idx);
                end
            end
            ptr_nxt[b] = PTR_W'((int'(win[b]) + 1) % NB_MASTERS);
        end
    end

    // With no requester win stays 0, so idle banks mirror master 0 (X-free).
    always_comb begin
        for (int b = 0; b < NB_BANKS; b++) begin
            b_req_o[b]            = any_req[b];
            b_add_o[32*b +: 32]   = m_add_i[32*int'(win[b]) +: 32];
            b_wen_o[b]            = m_wen_i[win[b]];
            b_wdata_o[32*b +: 32] = m_wdata_i[32*int'(win[b]) +: 32];
            b_be_o[4*b +: 4]      = m_be_i[4*int'(win[b]) +: 4];
        end
    end

    assign bank_gnt = any_req & b_gnt_i;

    always_comb begin
        m_gnt_o = '0;
        for (int m = 0; m < NB_MASTERS; m++) begin
            if (m_req_i[m] && any_req[tgt[m]] && (int'(win[tgt[m]]) == m) && b_gnt_i[tgt[m]]) begin
                m_gnt_o[m] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending <= '0;
            for (int b = 0; b < NB_BANKS; b++) begin
                ptr[b]   <= '0;
                owner[b] <= '0;
            end
        end else begin
            pending <= bank_gnt;
            for (int b = 0; b < NB_BANKS; b++) begin
                if (bank_gnt[b]) begin
                    ptr[b]   <= ptr_nxt[b];
                    owner[b] <= win[b];
                end
            end
        end
    end

    // Response return: each master owns at most one pending bank, so OR-merge is safe.
    always_comb begin
        m_r_valid_o = '0;
        m_r_rdata_o = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            if (!rst_i && pending[b] && b_r_valid_i[b]) begin
                m_r_valid_o[owner[b]]                = 1'b1;
                m_r_rdata_o[32*int'(owner[b]) +: 32] = b_r_rdata_i[32*b +: 32];
            end
        end
    end

endmodule

// File: doc/l2_intl_xbar.md
L2_INTL_XBAR -- requirements
Module: l2_intl_xbar

Interface
REQ-001 SHALL have parameter NB_MASTERS, default 4: number of TCDM master ports, at least 1.
REQ-002 SHALL have parameter NB_BANKS, default 4: number of interleaved L2 banks, a power of 2, at least 2.
REQ-003 SHALL have localparam BSEL_W = log2(NB_BANKS), the bank-select field width.
REQ-004 SHALL have port clk_i  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port m_req_i  in  NB_MASTERS: per-master request.
REQ-007 SHALL have port m_add_i  in  32*NB_MASTERS: per-master byte address.
REQ-008 SHALL have port m_wen_i  in  NB_MASTERS: 0 = write, 1 = read.
REQ-009 SHALL have port m_wdata_i  in  32*NB_MASTERS: write data.
REQ-010 SHALL have port m_be_i  in  4*NB_MASTERS: byte enables.
REQ-011 SHALL have port m_gnt_o  out  NB_MASTERS: per-master grant.
REQ-012 SHALL have ports m_r_valid_o  out  NB_MASTERS and m_r_rdata_o  out  32*NB_MASTERS: per-master response valid and data.
REQ-013 SHALL have ports b_req_o, b_add_o, b_wen_o, b_wdata_o, b_be_o  out  (1, 32, 1, 32, 4)*NB_BANKS: per-bank request fields.
REQ-014 SHALL have ports b_gnt_i  in  NB_BANKS, b_r_valid_i  in  NB_BANKS and b_r_rdata_i  in  32*NB_BANKS: per-bank grant and response.

Function
REQ-015 SHALL compute the target bank of master m as m_add_i[m][BSEL_W+1:2] (word-interleaved).
REQ-016 SHALL run one round-robin arbiter per bank over the masters requesting that bank in the same cycle.
REQ-017 SHALL, per bank, forward the winner's add, wen, wdata and be unchanged to the b_*_o outputs, with b_req_o = 1, in the same cycle (combinational, zero added request latency).
REQ-018 SHALL drive b_req_o low when no master requests a bank; b_add_o, b_wen_o, b_wdata_o and b_be_o are then don't-care, but SHALL be X-free (forward master 0).
REQ-019 SHALL assert m_gnt_o[m] iff master m is the winner for its target bank and that bank's b_gnt_i = 1, in the same cycle.
REQ-020 SHALL keep a per-bank priority pointer of log2(NB_MASTERS) bits (minimum 1), reset to 0; on a granted transfer with winner w it becomes (w+1) mod NB_MASTERS; with no grant it holds.
REQ-021 SHALL make the arbiter choose the first requester at or after the pointer, wrapping from NB_MASTERS-1 to 0.
REQ-022 SHALL record the winner index per bank on each granted transfer, in a register named owner[b], plus a pending[b] flag set to 1.
REQ-023 SHALL clear pending[b] in any cycle without a grant on bank b.
REQ-024 SHALL route a bank response (b_r_valid_i[b] = 1 with pending[b] = 1) to master owner[b]: that master's m_r_valid_o = 1 and m_r_rdata_o = b_r_rdata_i[b], combinationally.
REQ-025 SHALL return responses for writes as well as reads (r_valid pulse, rdata don't-care), giving fixed response latency of 1 cycle after grant.
REQ-026 SHALL ignore b_r_valid_i[b] when pending[b] = 0; m_r_valid_o stays 0 and m_r_rdata_o is 0.
REQ-027 SHALL guarantee at most one response per master per cycle: a master issues at most one request per cycle, so no two pending banks share an owner.
REQ-028 SHALL allow a master to hold req with changing address until granted; arbitration is re-evaluated every cycle with no lock.
REQ-029 SHALL allow back-to-back grants to the same master on consecutive cycles when it alone requests the bank.

Reset
REQ-030 SHALL, while rst_i = 1 at a clock edge: set all pointers to 0, all pending to 0 and all owner to 0.
REQ-031 SHALL, during reset, hold m_r_valid_o = 0 regardless of b_r_valid_i; responses in flight at reset are dropped.
REQ-032 SHALL keep m_gnt_o and b_req_o combinational during reset; masters SHALL NOT request while rst_i = 1.

Verification (NB_MASTERS=2, NB_BANKS=4, banks grant = req, r_valid 1 cycle later)
REQ-033 SHALL pass: M0 reads 0x1C01_0004 -> b_req_o[1] = 1 with add 0x1C01_0004, m_gnt_o[0] = 1 same cycle, m_r_valid_o[0] = 1 with bank-1 data next cycle.
REQ-034 SHALL pass: M0 and M1 both hold req to 0x1C01_0008 for 2 cycles after reset -> cycle 0 grants M0, cycle 1 grants M1; responses are routed to M0 then M1.
REQ-035 SHALL pass: M0 to 0x..00 and M1 to 0x..0C in the same cycle -> both granted (banks 0 and 3), both r_valid next cycle, no cross-routing.
REQ-036 SHALL pass: b_gnt_i[2] = 0 for 3 cycles with M1 requesting bank 2 -> m_gnt_o[1] = 0, pointer unchanged, no r_valid; grant follows once b_gnt_i = 1.
REQ-037 SHALL pass: grant in cycle N, rst_i = 1 in cycle N+1 with b_r_valid_i = 1 -> m_r_valid_o = 0; pointers read 0 after reset.
REQ-038 SHALL pass: spurious b_r_valid_i[3] = 1 with no prior grant -> all m_r_valid_o = 0.
